or1200_vlx_pack: RTL and testbench

OR1200_VLX_PACK -- requirements
Module: or1200_vlx_pack

---
 rtl/or1200_vlx_pack.sv | 133 +++++++++++++
 tb/tb_or1200_vlx_pack.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : or1200_vlx_pack                                                 |
// | Function : l.vlx variable-length code packer; emits a byte stream to memory|
// |            with 0x00 stuffing after every 0xFF byte and 1-padded flush.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module or1200_vlx_pack #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic [15:0]       value_i,
  input  logic [4:0]        len_i,
  input  logic              flush_i,
  input  logic              base_load_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              stall_o,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  input  logic              wr_ack_i,
  output logic [5:0]        bit_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT  = 2'd1,
    S_STUFF = 2'd2,
    S_PAD   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_buf, w_buf_nxt;
  logic [5:0]        r_cnt, w_cnt_nxt;
  logic              r_pend, w_pend_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_stall, r_wr_req;

  logic [4:0]  w_len;
  logic [15:0] w_mask;
  logic [31:0] w_set_buf;
  logic [5:0]  w_set_cnt;
  logic [5:0]  w_cnt_m8;
  logic [7:0]  w_byte;
  logic [31:0] w_pad_buf;
  logic        w_flush;

  assign w_len     = (len_i > 5'd16) ? 5'd16 : len_i;
  assign w_mask    = 16'hFFFF >> (5'd16 - w_len);
  assign w_set_buf = (r_buf << w_len) | {16'd0, value_i & w_mask};
  assign w_set_cnt = r_cnt + {1'b0, w_len};
  assign w_cnt_m8  = r_cnt - 6'd8;
  assign w_byte    = 8'(r_buf >> w_cnt_m8);
  // Pad with (8-cnt) ones; cnt is 1..7 whenever PAD is entered.
  assign w_pad_buf = (r_buf << (6'd8 - r_cnt)) | (32'hFF >> r_cnt);
  assign w_flush   = flush_i | r_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (base_load_i) w_addr_nxt = base_addr_i;
        if (set_i && (w_len != 5'd0)) begin
          w_buf_nxt = w_set_buf;
          w_cnt_nxt = w_set_cnt;
          if (w_flush) w_pend_nxt = 1'b1;
          if (w_set_cnt >= 6'd8) w_state_nxt = S_EMIT;
        end else if (w_flush) begin
          w_pend_nxt = 1'b0;
          if (r_cnt != 6'd0) w_state_nxt = S_PAD;
        end
      end
      S_EMIT: begin
        if (wr_ack_i) begin
          w_cnt_nxt  = w_cnt_m8;
          w_addr_nxt = r_addr + 1'b1;
          if (w_byte == 8'hFF)        w_state_nxt = S_STUFF;
          else if (w_cnt_m8 >= 6'd8)  w_state_nxt = S_EMIT;
          else                        w_state_nxt = S_IDLE;
        end
      end
      S_STUFF: begin
        if (wr_ack_i) begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = (r_cnt >= 6'd8) ? S_EMIT : S_IDLE;
        end
      end
      default: begin
        w_buf_nxt   = w_pad_buf;
        w_cnt_nxt   = 6'd8;
        w_state_nxt = S_EMIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_buf    <= 32'd0;
      r_cnt    <= 6'd0;
      r_pend   <= 1'b0;
      r_addr   <= '0;
      r_stall  <= 1'b0;
      r_wr_req <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_addr   <= w_addr_nxt;
      r_stall  <= (w_state_nxt != S_IDLE);
      r_wr_req <= (w_state_nxt == S_EMIT) || (w_state_nxt == S_STUFF);
    end
  end

  always_comb begin
    wr_data_o = 8'h00;
    if (r_state == S_EMIT) wr_data_o = w_byte;
  end

  assign stall_o   = r_stall;
  assign wr_req_o  = r_wr_req;
  assign wr_addr_o = r_addr;
  assign bit_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_or1200_vlx_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_or1200_vlx_pack                                              |
// | Function : directed vector bench for the l.vlx byte packer.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_or1200_vlx_pack;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        set_i, flush_i, base_load_i, wr_ack_i;
  logic [15:0] value_i;
  logic [4:0]  len_i;
  logic [31:0] base_addr_i;
  logic        stall_o, wr_req_o;
  logic [31:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic [5:0]  bit_cnt_o;

  or1200_vlx_pack #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .set_i(set_i), .value_i(value_i),
    .len_i(len_i), .flush_i(flush_i), .base_load_i(base_load_i),
    .base_addr_i(base_addr_i), .stall_o(stall_o), .wr_req_o(wr_req_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i),
    .bit_cnt_o(bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] value;
    logic [4:0]  len;
    logic [5:0]  cnt_acc;
    int          n;
    logic [31:0] bytes;
    logic [5:0]  cnt_end;
  } vec_t;

  vec_t        vecs[11];
  int          total = 0;
  int          bad = 0;
  logic [31:0] addr_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic append(input logic [15:0] v, input logic [4:0] l, input logic fl);
    set_i = 1'b1; value_i = v; len_i = l; flush_i = fl;
    tick();
    set_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic ack_byte(input string name, input logic [7:0] exp_b);
    chk({name, " req"}, 64'(wr_req_o), 64'd1);
    chk({name, " data"}, 64'(wr_data_o), 64'(exp_b));
    chk({name, " addr"}, 64'(wr_addr_o), 64'(addr_m));
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    addr_m++;
  endtask

  initial begin
    rst_i = 1'b0; set_i = 1'b0; flush_i = 1'b0; base_load_i = 1'b0; wr_ack_i = 1'b0;
    value_i = '0; len_i = '0; base_addr_i = '0;

    vecs[0]  = '{16'h0005, 5'd3,  6'd3,  0, 32'h0,         6'd3};
    vecs[1]  = '{16'h001F, 5'd5,  6'd8,  1, 32'hBF000000,  6'd0};
    vecs[2]  = '{16'h0000, 5'd0,  6'd0,  0, 32'h0,         6'd0};
    vecs[3]  = '{16'hABCD, 5'd4,  6'd4,  0, 32'h0,         6'd4};
    vecs[4]  = '{16'h0003, 5'd2,  6'd6,  0, 32'h0,         6'd6};
    vecs[5]  = '{16'h0002, 5'd2,  6'd8,  1, 32'hDE000000,  6'd0};
    vecs[6]  = '{16'h1234, 5'd31, 6'd16, 2, 32'h12340000,  6'd0};
    vecs[7]  = '{16'h0007, 5'd3,  6'd3,  0, 32'h0,         6'd3};
    vecs[8]  = '{16'h01FF, 5'd9,  6'd12, 2, 32'hFF000000,  6'd4};
    vecs[9]  = '{16'h0000, 5'd4,  6'd8,  1, 32'hF0000000,  6'd0};
    vecs[10] = '{16'hFFFF, 5'd16, 6'd16, 4, 32'hFF00FF00,  6'd0};

    #1;
    chk("rst stall", 64'(stall_o), 64'd0);
    chk("rst req", 64'(wr_req_o), 64'd0);
    chk("rst data", 64'(wr_data_o), 64'd0);
    chk("rst cnt", 64'(bit_cnt_o), 64'd0);
    chk("rst addr", 64'(wr_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    base_load_i = 1'b1; base_addr_i = 32'h1000;
    tick();
    base_load_i = 1'b0;
    chk("base addr", 64'(wr_addr_o), 64'h1000);
    chk("base stall", 64'(stall_o), 64'd0);
    addr_m = 32'h1000;

    for (int i = 0; i < 11; i++) begin
      append(vecs[i].value, vecs[i].len, 1'b0);
      chk($sformatf("v%0d cnt", i), 64'(bit_cnt_o), 64'(vecs[i].cnt_acc));
      chk($sformatf("v%0d stall", i), 64'(stall_o), 64'(vecs[i].n > 0));
      for (int k = 0; k < vecs[i].n; k++)
        ack_byte($sformatf("v%0d b%0d", i, k), 8'(vecs[i].bytes >> (24 - 8 * k)));
      chk($sformatf("v%0d end req", i), 64'(wr_req_o), 64'd0);
      chk($sformatf("v%0d end stall", i), 64'(stall_o), 64'd0);
      chk($sformatf("v%0d end cnt", i), 64'(bit_cnt_o), 64'(vecs[i].cnt_end));
    end
    chk("ff stream addr", 64'(wr_addr_o), 64'h1000 + 64'd11);

    // Flush after a partial code: PAD for one cycle, then 0xBF.
    append(16'h5, 5'd3, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("pad stall", 64'(stall_o), 64'd1);
    chk("pad req", 64'(wr_req_o), 64'd0);
    tick();
    ack_byte("flush", 8'hBF);
    chk("flush cnt", 64'(bit_cnt_o), 64'd0);
    chk("flush stall", 64'(stall_o), 64'd0);

    // Flush with empty accumulator does nothing.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("empty flush stall", 64'(stall_o), 64'd0);

    // Set and flush together: set first, flush pending, executes next cycle.
    append(16'h2, 5'd2, 1'b1);
    chk("pend cnt", 64'(bit_cnt_o), 64'd2);
    chk("pend stall", 64'(stall_o), 64'd0);
    tick();
    chk("pend pad stall", 64'(stall_o), 64'd1);
    tick();
    ack_byte("pend", 8'hBF);
    tick();
    chk("pend cleared", 64'(stall_o), 64'd0);

    // Ack held off for 5 cycles; inputs issued while stalled are ignored.
    append(16'h3C, 5'd8, 1'b0);
    for (int c = 0; c < 5; c++) begin
      base_load_i = 1'b1; base_addr_i = 32'hDEAD0000; set_i = 1'b1; value_i = 16'hFFFF; len_i = 5'd16;
      chk($sformatf("hold%0d req", c), 64'(wr_req_o), 64'd1);
      chk($sformatf("hold%0d data", c), 64'(wr_data_o), 64'h3C);
      chk($sformatf("hold%0d addr", c), 64'(wr_addr_o), 64'(addr_m));
      tick();
    end
    base_load_i = 1'b0; set_i = 1'b0;
    ack_byte("hold", 8'h3C);
    chk("hold one byte", 64'(wr_req_o), 64'd0);
    chk("hold cnt", 64'(bit_cnt_o), 64'd0);

    // Asynchronous reset in the middle of an EMIT.
    append(16'h55, 5'd8, 1'b0);
    chk("pre rst req", 64'(wr_req_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("async req", 64'(wr_req_o), 64'd0);
    chk("async stall", 64'(stall_o), 64'd0);
    chk("async cnt", 64'(bit_cnt_o), 64'd0);
    chk("async addr", 64'(wr_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    addr_m = 32'd0;
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("stray ack addr", 64'(wr_addr_o), 64'd0);
    append(16'h81, 5'd8, 1'b0);
    ack_byte("fresh", 8'h81);
    chk("fresh cnt", 64'(bit_cnt_o), 64'd0);
    chk("fresh addr", 64'(wr_addr_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
